// File: rtl/rvfi_seq_pkg.sv
// rtl/rvfi_seq_pkg.sv - shared types and constants for the RVFI check sequencer
package rvfi_seq_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    PH_RESET = 2'd0,
    PH_RUN   = 2'd1,
    PH_ARMED = 2'd2,
    PH_DONE  = 2'd3
  } phase_e;

endpackage

// File: rtl/rvfi_check_sequencer_if.sv
// rtl/rvfi_check_sequencer_if.sv - retirement input and checker control bundle
interface rvfi_check_sequencer_if #(
  parameter int NRET = 1
);
  import rvfi_seq_pkg::*;

  logic [NRET-1:0]  rvfi_valid;
  logic             checker_reset;
  logic             trig;
  logic             check;
  logic [CNT_W-1:0] cycle;
  logic [CNT_W-1:0] retire_cnt;
  phase_e           phase;
  logic             timeout;

  modport master (
    output rvfi_valid,
    input  checker_reset, trig, check, cycle, retire_cnt, phase, timeout
  );

  modport slave (
    input  rvfi_valid,
    output checker_reset, trig, check, cycle, retire_cnt, phase, timeout
  );

endinterface

// File: rtl/rvfi_retire_counter.sv
// rtl/rvfi_retire_counter.sv - popcount of retirement valids plus saturating accumulator
module rvfi_retire_counter
  import rvfi_seq_pkg::*;
#(
  parameter int NRET = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic [NRET-1:0]  valid_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W:0]   sum_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   pc;

  always_comb begin
    pc = '0;
    for (int i = 0; i < NRET; i++) begin
      pc = pc + {{CNT_W{1'b0}}, valid_i[i]};
    end
  end

  // The 9-bit look-ahead sum lets the trigger see this cycle's retirements.
  assign sum_o = {1'b0, count_q} + pc;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (sum_o > {1'b0, CNT_MAX}) begin
        count_d = CNT_MAX;
      end else begin
        count_d = sum_o[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rvfi_check_sequencer.sv
// rtl/rvfi_check_sequencer.sv - drives reset, trigger and check strobes for an RVFI checker
module rvfi_check_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int RESET_CYCLES   = 1,
  parameter int TRIG_CYCLE     = 10,
  parameter int CHECK_CYCLE    = 20,
  parameter int TRIG_ON_RETIRE = 0,
  parameter int NRET           = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  rvfi_check_sequencer_if.slave   bus
);

  if (RESET_CYCLES > 255) begin : g_err_reset_cycles
    $error("RESET_CYCLES must not exceed 255");
  end
  if (CHECK_CYCLE > 254) begin : g_err_check_cycle
    $error("CHECK_CYCLE must not exceed 254");
  end
  if (TRIG_ON_RETIRE == 0 && TRIG_CYCLE >= CHECK_CYCLE) begin : g_err_trig_cycle
    $error("TRIG_CYCLE must be below CHECK_CYCLE in cycle mode");
  end

  logic [CNT_W-1:0] cycle_q, cycle_d;
  phase_e           phase_q;
  logic             timeout_q;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W:0]   retire_sum;
  logic             checker_reset;
  logic             trig, check;
  logic             cyc_hit, ret_hit;

  assign cycle_d = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + 8'd1;

  assign checker_reset = int'(cycle_q) < RESET_CYCLES;

  rvfi_retire_counter #(
    .NRET (NRET)
  ) u_retire (
    .clock   (clock),
    .reset   (reset),
    .en_i    (!checker_reset),
    .valid_i (bus.rvfi_valid),
    .count_o (retire_cnt),
    .sum_o   (retire_sum)
  );

  // The mode parameter folds away the unused path, so rvfi_valid only feeds trig in retire mode.
  assign cyc_hit = int'(cycle_q) == TRIG_CYCLE;
  assign ret_hit = int'(retire_sum) >= TRIG_CYCLE;
  assign trig    = (phase_q == PH_RUN) && ((TRIG_ON_RETIRE != 0) ? ret_hit : cyc_hit);
  assign check   = (phase_q == PH_ARMED) && (int'(cycle_q) == CHECK_CYCLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      phase_q   <= PH_RESET;
      timeout_q <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      case (phase_q)
        PH_RESET: begin
          if (int'(cycle_q) + 1 >= RESET_CYCLES) begin
            phase_q <= PH_RUN;
          end
        end
        PH_RUN: begin
          // A trigger landing on the check cycle still arms; check can then never match.
          if (trig) begin
            phase_q <= PH_ARMED;
          end else if (int'(cycle_q) == CHECK_CYCLE) begin
            phase_q   <= PH_DONE;
            timeout_q <= 1'b1;
          end
        end
        PH_ARMED: begin
          if (check) begin
            phase_q <= PH_DONE;
          end
        end
        default: begin
          phase_q <= PH_DONE;
        end
      endcase
    end
  end

  assign bus.checker_reset = checker_reset;
  assign bus.trig          = trig;
  assign bus.check         = check;
  assign bus.cycle         = cycle_q;
  assign bus.retire_cnt    = retire_cnt;
  assign bus.phase         = phase_q;
  assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// tb/tb_rvfi_check_sequencer.sv - directed vector bench for the RVFI check sequencer
module tb_rvfi_check_sequencer;
  import rvfi_seq_pkg::*;

  logic       clock = 1'b0;
  logic [4:0] rst   = '1;
  int         sel   = 0;
  logic [1:0] vdrv  = '0;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clock = ~clock;

  rvfi_check_sequencer_if #(.NRET(1)) b0();
  rvfi_check_sequencer_if #(.NRET(2)) b1();
  rvfi_check_sequencer_if #(.NRET(1)) b2();
  rvfi_check_sequencer_if #(.NRET(1)) b3();
  rvfi_check_sequencer_if #(.NRET(1)) b4();

  assign b0.rvfi_valid = (sel == 0) ? vdrv[0] : 1'b0;
  assign b1.rvfi_valid = (sel == 1) ? vdrv    : 2'b00;
  assign b2.rvfi_valid = (sel == 2) ? vdrv[0] : 1'b0;
  assign b3.rvfi_valid = (sel == 3) ? vdrv[0] : 1'b0;
  assign b4.rvfi_valid = (sel == 4) ? vdrv[0] : 1'b0;

  rvfi_check_sequencer u0 (.clock(clock), .reset(rst[0]), .bus(b0));
  rvfi_check_sequencer #(.TRIG_ON_RETIRE(1), .TRIG_CYCLE(3), .NRET(2))
    u1 (.clock(clock), .reset(rst[1]), .bus(b1));
  rvfi_check_sequencer #(.TRIG_ON_RETIRE(1), .TRIG_CYCLE(50))
    u2 (.clock(clock), .reset(rst[2]), .bus(b2));
  rvfi_check_sequencer #(.RESET_CYCLES(3))
    u3 (.clock(clock), .reset(rst[3]), .bus(b3));
  rvfi_check_sequencer #(.TRIG_ON_RETIRE(1), .TRIG_CYCLE(20))
    u4 (.clock(clock), .reset(rst[4]), .bus(b4));

  logic       o_crst, o_trig, o_check, o_to;
  logic [1:0] o_ph;
  logic [7:0] o_cyc, o_rc;

  always_comb begin
    o_crst = b0.checker_reset; o_trig = b0.trig; o_check = b0.check;
    o_to = b0.timeout; o_ph = b0.phase; o_cyc = b0.cycle; o_rc = b0.retire_cnt;
    case (sel)
      1: begin
        o_crst = b1.checker_reset; o_trig = b1.trig; o_check = b1.check;
        o_to = b1.timeout; o_ph = b1.phase; o_cyc = b1.cycle; o_rc = b1.retire_cnt;
      end
      2: begin
        o_crst = b2.checker_reset; o_trig = b2.trig; o_check = b2.check;
        o_to = b2.timeout; o_ph = b2.phase; o_cyc = b2.cycle; o_rc = b2.retire_cnt;
      end
      3: begin
        o_crst = b3.checker_reset; o_trig = b3.trig; o_check = b3.check;
        o_to = b3.timeout; o_ph = b3.phase; o_cyc = b3.cycle; o_rc = b3.retire_cnt;
      end
      4: begin
        o_crst = b4.checker_reset; o_trig = b4.trig; o_check = b4.check;
        o_to = b4.timeout; o_ph = b4.phase; o_cyc = b4.cycle; o_rc = b4.retire_cnt;
      end
      default: begin
      end
    endcase
  end

  typedef struct {
    int         dut;
    logic [1:0] valid;
    int         valid_from;
    int         ncyc;
    int         rst_cyc;
    int         trig_at;
    int         check_at;
    int         spot_cyc;
    logic [1:0] spot_phase;
    logic       spot_to;
    logic [7:0] spot_rc;
  } tv_t;

  tv_t tv[8];

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, sel, c, act, exp);
    end
  endtask

  task automatic chk_reset_state(input int c);
    chk("rst_cycle", c, o_cyc, 0);
    chk("rst_retire", c, o_rc, 0);
    chk("rst_phase", c, o_ph, 0);
    chk("rst_timeout", c, o_to, 0);
    chk("rst_crst", c, o_crst, 1);
    chk("rst_trig", c, o_trig, 0);
    chk("rst_check", c, o_check, 0);
  endtask

  // Leaves the selected DUT in cycle 0, sampled just after the falling edge.
  task automatic do_reset(input int s);
    sel  = s;
    vdrv = '0;
    rst  = '1;
    @(negedge clock);
    @(negedge clock);
    #1;
    chk_reset_state(-1);
    rst[s] = 1'b0;
  endtask

  task automatic run_vec(input tv_t t);
    do_reset(t.dut);
    for (int c = 0; c < t.ncyc; c++) begin
      if (c > 0) @(negedge clock);
      vdrv = (c >= t.valid_from) ? t.valid : 2'b00;
      #1;
      chk("cycle", c, o_cyc, (c > 255) ? 255 : c);
      chk("checker_reset", c, o_crst, (c < t.rst_cyc) ? 1 : 0);
      chk("trig", c, o_trig, (c == t.trig_at) ? 1 : 0);
      chk("check", c, o_check, (c == t.check_at) ? 1 : 0);
      if (c == t.spot_cyc) begin
        chk("phase", c, o_ph, t.spot_phase);
        chk("timeout", c, o_to, t.spot_to);
        chk("retire_cnt", c, o_rc, t.spot_rc);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{0, 2'b00, 0,  30, 1, 10, 20, 21, 2'd3, 1'b0, 8'd0};
    tv[1] = '{0, 2'b01, 0, 300, 1, 10, 20, 299, 2'd3, 1'b0, 8'd255};
    tv[2] = '{0, 2'b01, 0, 257, 1, 10, 20, 255, 2'd3, 1'b0, 8'd254};
    tv[3] = '{1, 2'b11, 1,  25, 1,  2, 20,  3, 2'd2, 1'b0, 8'd4};
    tv[4] = '{2, 2'b00, 0,  30, 1, -1, -1, 21, 2'd3, 1'b1, 8'd0};
    tv[5] = '{2, 2'b00, 0,  30, 1, -1, -1, 29, 2'd3, 1'b1, 8'd0};
    tv[6] = '{3, 2'b01, 0,  25, 3, 10, 20,  4, 2'd1, 1'b0, 8'd1};
    tv[7] = '{4, 2'b01, 1,  40, 1, 20, -1, 39, 2'd2, 1'b0, 8'd38};

    for (int i = 0; i < 8; i++) begin
      run_vec(tv[i]);
    end

    // Asynchronous reset while armed, then a clean restart.
    do_reset(0);
    for (int c = 0; c < 15; c++) @(negedge clock);
    #1;
    chk("armed_before_reset", 15, o_ph, 2);
    #2;
    rst[0] = 1'b1;
    #1;
    chk_reset_state(15);
    @(negedge clock);
    rst[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      chk("retrig", c, o_trig, (c == 10) ? 1 : 0);
    end

    // Asynchronous reset from DONE clears the sticky timeout.
    do_reset(2);
    for (int c = 0; c < 25; c++) @(negedge clock);
    #1;
    chk("timeout_before_reset", 25, o_to, 1);
    #2;
    rst[2] = 1'b1;
    #1;
    chk_reset_state(25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
